// File: rtl/execute_flag_pkg.sv
// Shared types and constants for the in-order flag commit scheduler.
package execute_flag_pkg;

  localparam int P_FLAG_W   = 5;
  localparam int P_UNIT_NUM = 4;

  localparam int UNIT_SHIFT = 0;
  localparam int UNIT_ADDER = 1;
  localparam int UNIT_MUL   = 2;
  localparam int UNIT_LOGIC = 3;

  typedef struct packed {
    logic                alloc;
    logic                done;
    logic [P_FLAG_W-1:0] flags;
  } flag_entry_t;

  localparam int P_ENTRY_W = $bits(flag_entry_t);

endpackage

// File: rtl/execute_flag_commit_entry.sv
// One scheduler slot: allocation, completion capture and commit clear.
module execute_flag_commit_entry
  import execute_flag_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                alloc_i,
  input  logic                clear_i,
  input  logic                done_i,
  input  logic [P_FLAG_W-1:0] flags_i,
  output flag_entry_t         entry_o
);

  flag_entry_t entry_q;
  flag_entry_t entry_d;

  // Commit clear wins over a late completion to the same slot.
  always_comb begin
    entry_d = entry_q;
    if (clear_i) begin
      entry_d = '0;
    end else begin
      if (alloc_i) begin
        entry_d.alloc = 1'b1;
        entry_d.done  = 1'b0;
      end
      if (done_i && entry_q.alloc) begin
        entry_d.done  = 1'b1;
        entry_d.flags = flags_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/execute_flag_commit_scheduler.sv
// In-order commit of out-of-order flag results; optional same-edge head bypass
// is enabled by defining EXEC_FLAG_COMMIT_BYPASS_EN.
module execute_flag_commit_scheduler
  import execute_flag_pkg::*;
#(
  parameter int P_DEPTH = 4,
  parameter int P_TAG_W = 2
) (
  input  logic                            iCLOCK,
  input  logic                            iRESET_SYNC,
  input  logic                            iCTRL_HOLD,
  input  logic                            iFLUSH,
  input  logic                            iISSUE_VALID,
  output logic                            oISSUE_READY,
  output logic [P_TAG_W-1:0]              oISSUE_TAG,
  input  logic [P_UNIT_NUM-1:0]           iUNIT_VALID,
  input  logic [P_UNIT_NUM*P_TAG_W-1:0]   iUNIT_TAG,
  input  logic [P_UNIT_NUM*P_FLAG_W-1:0]  iUNIT_FLAG,
  output logic                            oFLAG_WE,
  output logic [P_FLAG_W-1:0]             oFLAG_DATA,
  output logic                            oFLAG_STALL,
  output logic [P_TAG_W:0]                oPENDING,
  output logic                            oERR_SPURIOUS
);

  localparam logic [P_TAG_W:0] LP_FULL = (P_TAG_W+1)'(P_DEPTH);

  // Issue handshake: an instruction is accepted on a cycle where
  // iISSUE_VALID & oISSUE_READY & !iCTRL_HOLD & !iFLUSH; READY uses only the registered count.

  flag_entry_t         entry_w   [P_DEPTH];
  logic [P_DEPTH-1:0]  hit;
  logic [P_FLAG_W-1:0] hit_flags [P_DEPTH];

  logic [P_TAG_W-1:0]  head_q, head_d;
  logic [P_TAG_W-1:0]  tail_q, tail_d;
  logic [P_TAG_W:0]    count_q, count_d;
  logic                we_q, we_d;
  logic [P_FLAG_W-1:0] data_q, data_d;
  logic                err_q, err_d;

  logic                accept;
  logic                spurious;
  logic                commit_std;
  logic                commit_byp;
  logic                commit;
  logic [P_FLAG_W-1:0] commit_flags;
  flag_entry_t         head_e;

  // Later units overwrite earlier ones, so the highest unit index wins a tag collision.
  always_comb begin
    for (int i = 0; i < P_DEPTH; i++) begin
      hit[i]       = 1'b0;
      hit_flags[i] = '0;
      for (int k = 0; k < P_UNIT_NUM; k++) begin
        if (iUNIT_VALID[k] && (iUNIT_TAG[k*P_TAG_W +: P_TAG_W] == P_TAG_W'(i))) begin
          hit[i]       = 1'b1;
          hit_flags[i] = iUNIT_FLAG[k*P_FLAG_W +: P_FLAG_W];
        end
      end
    end
  end

  always_comb begin
    spurious = 1'b0;
    for (int k = 0; k < P_UNIT_NUM; k++) begin
      if (iUNIT_VALID[k] && !entry_w[iUNIT_TAG[k*P_TAG_W +: P_TAG_W]].alloc) begin
        spurious = 1'b1;
      end
    end
  end

  assign head_e     = entry_w[head_q];
  assign accept     = iISSUE_VALID && oISSUE_READY && !iCTRL_HOLD && !iFLUSH;
  assign commit_std = !iCTRL_HOLD && !iFLUSH && head_e.alloc && head_e.done;
`ifdef EXEC_FLAG_COMMIT_BYPASS_EN
  assign commit_byp = !iCTRL_HOLD && !iFLUSH && head_e.alloc && !head_e.done && hit[head_q];
`else
  assign commit_byp = 1'b0;
`endif
  assign commit       = commit_std || commit_byp;
  assign commit_flags = commit_byp ? hit_flags[head_q] : head_e.flags;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    we_d    = 1'b0;
    data_d  = data_q;
    err_d   = 1'b0;
    if (iFLUSH) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      err_d   = spurious;
      tail_d  = tail_q + P_TAG_W'(accept);
      head_d  = head_q + P_TAG_W'(commit);
      count_d = count_q + (P_TAG_W+1)'(accept) - (P_TAG_W+1)'(commit);
      if (commit) begin
        we_d   = 1'b1;
        data_d = commit_flags;
      end
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < P_DEPTH; g++) begin : g_entry
    execute_flag_commit_entry u_entry (
      .clk_i   (iCLOCK),
      .rst_i   (iRESET_SYNC),
      .flush_i (iFLUSH),
      .alloc_i (accept && (tail_q == P_TAG_W'(g))),
      .clear_i (commit && (head_q == P_TAG_W'(g))),
      .done_i  (hit[g]),
      .flags_i (hit_flags[g]),
      .entry_o (entry_w[g])
    );
  end

  assign oISSUE_READY  = (count_q != LP_FULL);
  assign oISSUE_TAG    = tail_q;
  assign oFLAG_STALL   = (count_q != '0);
  assign oPENDING      = count_q;
  assign oFLAG_WE      = we_q;
  assign oFLAG_DATA    = data_q;
  assign oERR_SPURIOUS = err_q;

endmodule

// File: tb/tb_execute_flag_commit_scheduler.sv
// Directed scoreboard bench: expected {cycle, flags} commits are queued at stimulus time.
module tb_execute_flag_commit_scheduler;

`ifdef EXEC_FLAG_COMMIT_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        rst;
  logic        hold;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_tag;
  logic [3:0]  unit_valid;
  logic [7:0]  unit_tag;
  logic [19:0] unit_flag;
  logic        flag_we;
  logic [4:0]  flag_data;
  logic        flag_stall;
  logic [2:0]  pending;
  logic        err_spurious;

  execute_flag_commit_scheduler #(.P_DEPTH(4), .P_TAG_W(2)) dut (
    .iCLOCK        (clk),
    .iRESET_SYNC   (rst),
    .iCTRL_HOLD    (hold),
    .iFLUSH        (flush),
    .iISSUE_VALID  (issue_valid),
    .oISSUE_READY  (issue_ready),
    .oISSUE_TAG    (issue_tag),
    .iUNIT_VALID   (unit_valid),
    .iUNIT_TAG     (unit_tag),
    .iUNIT_FLAG    (unit_flag),
    .oFLAG_WE      (flag_we),
    .oFLAG_DATA    (flag_data),
    .oFLAG_STALL   (flag_stall),
    .oPENDING      (pending),
    .oERR_SPURIOUS (err_spurious)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [20:0] exp_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_we(input int at, input logic [4:0] d);
    exp_q.push_back({16'(at), d});
  endtask

  always @(negedge clk) begin
    logic [20:0] e;
    if (!rst) begin
      if (flag_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", int'(flag_data), -1);
        end else begin
          e = exp_q.pop_front();
          check("we_cycle", cyc, int'(e[20:5]));
          check("we_data", int'(flag_data), int'(e[4:0]));
        end
      end
      if (err_spurious) err_cnt++;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_in();
    hold        = 1'b0;
    flush       = 1'b0;
    issue_valid = 1'b0;
    unit_valid  = '0;
    unit_tag    = '0;
    unit_flag   = '0;
  endtask

  task automatic set_unit(input int k, input int tag, input logic [4:0] f);
    unit_valid[k]        = 1'b1;
    unit_tag[k*2 +: 2]   = tag[1:0];
    unit_flag[k*5 +: 5]  = f;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  int t0;
  int c;

  initial begin
    idle_in();
    rst = 1'b1;
    steps(2);
    sample();
    check("rst_ready", int'(issue_ready), 1);
    check("rst_stall", int'(flag_stall), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_we_data_err", int'({flag_we, flag_data, err_spurious}), 0);
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      sample();
      check("idle_vec", int'({issue_ready, flag_stall, pending, flag_we}), 'b100000);
    end

    // 2: out-of-order completion, in-order commit
    step();
    t0 = cyc;
    issue_valid = 1'b1;
    sample();
    check("t2_tag0", int'(issue_tag), 0);
    step();
    sample();
    check("t2_tag1", int'(issue_tag), 1);
    step();
    issue_valid = 1'b0;
    step();
    set_unit(1, 1, 5'h04);
    step();
    idle_in();
    steps(4);
    set_unit(2, 0, 5'h11);
    expect_we(t0 + 10 - BYP, 5'h11);
    expect_we(t0 + 11 - BYP, 5'h04);
    step();
    idle_in();
    steps(4);
    sample();
    check("t2_drained", int'({flag_stall, pending}), 0);

    // 3: fill, refuse, free head, wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1;
      sample();
      check("t3_tag", int'({issue_ready, issue_tag}), 4 + i);
      step();
    end
    sample();
    check("t3_full", int'({issue_ready, pending}), 4);
    step();
    sample();
    check("t3_no_5th", int'(pending), 4);
    issue_valid = 1'b0;
    step();
    c = cyc;
    set_unit(0, 0, 5'h0A);
    expect_we(c + 2 - BYP, 5'h0A);
    step();
    idle_in();
    if (BYP == 0) step();
    sample();
    check("t3_freed", int'({issue_ready, issue_tag, pending}), 'b100011);
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    sample();
    check("t3_wrap", int'({pending, issue_tag}), 'b10001);

    // 4: four completions in one cycle, then a same-tag collision
    do_reset();
    issue_valid = 1'b1;
    steps(4);
    issue_valid = 1'b0;
    c = cyc;
    for (int k = 0; k < 4; k++) begin
      set_unit(k, k, 5'(k + 1));
      expect_we(c + 2 - BYP + k, 5'(k + 1));
    end
    step();
    idle_in();
    steps(5);
    sample();
    check("t4_drained", int'({flag_stall, pending}), 0);
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    c = cyc;
    set_unit(0, 0, 5'h07);
    set_unit(3, 0, 5'h18);
    expect_we(c + 2 - BYP, 5'h18);
    step();
    idle_in();
    steps(3);

    // 5: flush overrides issue and completion; late result is spurious
    do_reset();
    issue_valid = 1'b1;
    steps(3);
    issue_valid = 1'b0;
    sample();
    check("t5_pending3", int'(pending), 3);
    flush = 1'b1;
    issue_valid = 1'b1;
    set_unit(0, 0, 5'h1F);
    step();
    idle_in();
    sample();
    check("t5_flushed", int'({issue_ready, flag_stall, pending, issue_tag, flag_we, err_spurious}), 'b10000000000 >> 2);
    set_unit(1, 1, 5'h03);
    step();
    idle_in();
    sample();
    check("t5_err_pulse", int'({err_spurious, flag_we, pending}), 'b10000);
    step();
    sample();
    check("t5_err_clear", int'(err_spurious), 0);

    // 6: hold blocks commit and issue, completion still captured
    do_reset();
    issue_valid = 1'b1;
    step();
    hold = 1'b1;
    c = cyc;
    set_unit(2, 0, 5'h15);
    expect_we(c + 4, 5'h15);
    step();
    unit_valid = '0;
    steps(2);
    hold = 1'b0;
    issue_valid = 1'b0;
    sample();
    check("t6_hold_no_issue", int'(pending), 1);
    steps(2);
    sample();
    check("t6_drained", int'(pending), 0);
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    c = cyc;
    set_unit(1, 1, 5'h0C);
    expect_we(c + 2 - BYP, 5'h0C);
    step();
    idle_in();
    steps(3);

    sample();
    check("exp_q_empty", exp_q.size(), 0);
    check("err_pulses", err_cnt, 1);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
